// File: rtl/simd_padd_pipe.sv
// Packed-SIMD add/subtract unit with a two-stage elastic pipeline.
// Operands are split into XLEN/LANE_W independent lanes. Each beat selects
// add/sub, wrap/saturate and signed/unsigned lanes.
// Optional build macro SIMD_SAT_FLAG_EN adds a sticky saturation flag
// (sat_flag) with a clear input (sat_clr).
module simd_padd_pipe #(
  parameter int XLEN   = 32,
  parameter int LANE_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            op_sub,
  input  logic            op_sat,
  input  logic            op_unsigned,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            sat_any
`ifdef SIMD_SAT_FLAG_EN
  ,
  output logic            sat_flag,
  input  logic            sat_clr
`endif
);

  localparam int NLANES = XLEN / LANE_W;

  generate
    if (!(LANE_W == 8 || LANE_W == 16 || LANE_W == 32) || (XLEN % LANE_W) != 0) begin : g_bad_param
      $error("simd_padd_pipe: LANE_W must be 8, 16 or 32 and divide XLEN");
    end
  endgenerate

  // One extra bit per lane keeps the carry/borrow/overflow information
  // that stage 2 needs to decide on clamping.
  function automatic logic signed [LANE_W:0] ext_op(
    input logic [LANE_W-1:0] a,
    input logic [LANE_W-1:0] b,
    input logic              sub,
    input logic              uns
  );
    logic signed [LANE_W:0] xa;
    logic signed [LANE_W:0] xb;
    xa = uns ? $signed({1'b0, a}) : $signed({a[LANE_W-1], a});
    xb = uns ? $signed({1'b0, b}) : $signed({b[LANE_W-1], b});
    return sub ? (xa - xb) : (xa + xb);
  endfunction

  // Returns {clamp_event, lane_value} for one lane.
  function automatic logic [LANE_W:0] sat_lane(
    input logic signed [LANE_W:0] e,
    input logic                   sat,
    input logic                   uns,
    input logic                   sub
  );
    logic [LANE_W-1:0] lane;
    logic              clamp;
    lane  = e[LANE_W-1:0];
    clamp = 1'b0;
    if (sat) begin
      if (!uns) begin
        if (e[LANE_W] != e[LANE_W-1]) begin
          clamp = 1'b1;
          lane  = e[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
        end
      end else if (e[LANE_W]) begin
        clamp = 1'b1;
        lane  = sub ? '0 : '1;
      end
    end
    return {clamp, lane};
  endfunction

  logic                   vld_p1;
  logic                   vld_p2;
  logic                   s1_adv;
  logic                   s2_adv;
  logic signed [LANE_W:0] ext_p1 [NLANES];
  logic                   sub_p1;
  logic                   sat_p1;
  logic                   uns_p1;
  logic [XLEN-1:0]        res_d;
  logic                   sat_d;
  logic [LANE_W:0]        lane_r;

  assign s2_adv    = !vld_p2 || out_ready;
  assign s1_adv    = !vld_p1 || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = vld_p2;

  // ---- stage 1: extended per-lane sum/difference ----
  // Capture the extended lane results and the beat's mode bits on acceptance.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      for (int i = 0; i < NLANES; i++) begin
        ext_p1[i] <= ext_op(op_a[i*LANE_W +: LANE_W], op_b[i*LANE_W +: LANE_W],
                            op_sub, op_unsigned);
      end
      sub_p1 <= op_sub;
      sat_p1 <= op_sat;
      uns_p1 <= op_unsigned;
    end
  end

  // ---- stage 2: clamp or wrap each lane, collect clamp events ----
  // Combine the per-lane clamp decisions into the packed result and sat_any.
  always_comb begin
    res_d  = '0;
    sat_d  = 1'b0;
    lane_r = '0;
    for (int i = 0; i < NLANES; i++) begin
      lane_r                     = sat_lane(ext_p1[i], sat_p1, uns_p1, sub_p1);
      res_d[i*LANE_W +: LANE_W]  = lane_r[LANE_W-1:0];
      sat_d                      = sat_d | lane_r[LANE_W];
    end
  end

  // Advance the valid bits and the output register under the elastic rules.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      result  <= '0;
      sat_any <= 1'b0;
    end else begin
      if (s1_adv) vld_p1 <= in_valid;
      if (s2_adv) vld_p2 <= vld_p1;
      if (s2_adv && vld_p1) begin
        result  <= res_d;
        sat_any <= sat_d;
      end
    end
  end

`ifdef SIMD_SAT_FLAG_EN
  // Sticky flag: set when a clamped beat is consumed; set beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (vld_p2 && out_ready && sat_any) begin
      sat_flag <= 1'b1;
    end else if (sat_clr) begin
      sat_flag <= 1'b0;
    end
  end
`endif

endmodule
